// File: rtl/knight_rider_checker.sv
// Knight-rider LED bus monitor: locks on 81/18 anchors, checks each strobe against the legal successor.
// One cycle from a sampled led_valid to registered outputs; no backpressure, every strobe is consumed.
module knight_rider_checker #(
    parameter logic [21:0] TIMEOUT = 22'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  led_in,
    input  logic        led_valid,
    output logic        locked,
    output logic [2:0]  phase,
    output logic        dir,
    output logic        err,
    output logic [7:0]  err_count,
    output logic [15:0] cycle_count
);

    typedef enum logic {HUNT, TRACK} state_t;

    localparam logic [7:0] ANCHOR_CONV = 8'h81;
    localparam logic [7:0] ANCHOR_DIV  = 8'h18;

    state_t      state;
    logic [21:0] idle_timer;

    logic [2:0]  next_phase;
    logic [7:0]  expected;
    logic [7:0]  err_count_inc;
    logic        timeout_hit;

    function automatic logic [7:0] pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    pattern = 8'h81;
            3'd1:    pattern = 8'h42;
            3'd2:    pattern = 8'h24;
            3'd3:    pattern = 8'h18;
            3'd4:    pattern = 8'h24;
            3'd5:    pattern = 8'h42;
            default: pattern = 8'h00;
        endcase
    endfunction

    always_comb begin
        next_phase    = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
        expected      = pattern(next_phase);
        err_count_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
        timeout_hit   = (idle_timer == TIMEOUT - 22'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            locked      <= 1'b0;
            phase       <= 3'd0;
            dir         <= 1'b0;
            err         <= 1'b0;
            err_count   <= 8'd0;
            cycle_count <= 16'd0;
            idle_timer  <= 22'd0;
        end else begin
            err <= 1'b0;
            if (led_valid) begin
                idle_timer <= 22'd0;
                if (state == HUNT) begin
                    if (led_in == ANCHOR_CONV) begin
                        state  <= TRACK;
                        locked <= 1'b1;
                        phase  <= 3'd0;
                        dir    <= 1'b0;
                    end else if (led_in == ANCHOR_DIV) begin
                        state  <= TRACK;
                        locked <= 1'b1;
                        phase  <= 3'd3;
                        dir    <= 1'b1;
                    end
                end else if (led_in == expected) begin
                    phase <= next_phase;
                    dir   <= (next_phase >= 3'd3);
                    if (next_phase == 3'd0)
                        cycle_count <= cycle_count + 16'd1;
                end else begin
                    err       <= 1'b1;
                    err_count <= err_count_inc;
                    // An anchor mismatch re-anchors in place rather than dropping lock
                    if (led_in == ANCHOR_CONV) begin
                        phase <= 3'd0;
                        dir   <= 1'b0;
                    end else if (led_in == ANCHOR_DIV) begin
                        phase <= 3'd3;
                        dir   <= 1'b1;
                    end else begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                end
            end else if (state == HUNT) begin
                idle_timer <= 22'd0;
            end else if (timeout_hit) begin
                state      <= HUNT;
                locked     <= 1'b0;
                err        <= 1'b1;
                err_count  <= err_count_inc;
                idle_timer <= 22'd0;
            end else begin
                idle_timer <= idle_timer + 22'd1;
            end
        end
    end

endmodule

// File: doc/knight_rider_checker.md
# knight_rider_checker

Receive-side monitor for the knight-rider LED pattern bus. It samples each new 8-bit pattern presented with a one-cycle strobe, locks onto the six-step converge/diverge sequence, and checks every later pattern against the legal successor. It reports the current phase, the sweep direction, the number of completed cycles and an error count. It sits on the LED bus next to the pattern generator and serves as an in-system self-check and bench scoreboard.

## Interface
- TIMEOUT, 22'd64: locked idle limit, in clk cycles without led_valid; legal range 2..2^22-1
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- led_in  input  8  pattern under test; sampled only when led_valid=1
- led_valid  input  1  one-cycle strobe marking a new pattern on led_in
- locked  output  1  1 = sequence anchored and tracking
- phase  output  3  current sequence index 0..5; meaningful only when locked=1
- dir  output  1  0 = converging (phase 0..2), 1 = diverging (phase 3..5)
- err  output  1  one-cycle pulse on mismatch or timeout
- err_count  output  8  saturating error counter
- cycle_count  output  16  completed full sequences, wraps at 2^16

## Operation
- Legal sequence, indexed by phase:
  - P0 = 8'h81
  - P1 = 8'h42
  - P2 = 8'h24
  - P3 = 8'h18
  - P4 = 8'h24
  - P5 = 8'h42
  - after P5, back to P0.
- Anchors: 8'h81 and 8'h18 are unique in the sequence. 8'h42 and 8'h24 are ambiguous and never anchor.
- States: HUNT (locked=0) and TRACK (locked=1).
- HUNT, on led_valid:
  - led_in = 8'h81: go to TRACK, phase ← 0.
  - led_in = 8'h18: go to TRACK, phase ← 3.
  - any other value: stay in HUNT. No err is raised.
- TRACK, on led_valid, expected = P[(phase+1) mod 6]:
  - led_in == expected: phase ← (phase+1) mod 6.
    - If the transition is phase 5 → 0, cycle_count increments (modulo 2^16).
  - Mismatch: pulse err and increment err_count, saturating at 255.
    - If led_in is an anchor, re-anchor in the same update (phase 0 or 3, locked stays 1).
    - Otherwise go to HUNT (locked ← 0). phase holds its last value.
- Idle timer (22 bits):
  - Cleared on any cycle with led_valid=1, and every cycle in HUNT.
  - Increments on each TRACK cycle with led_valid=0.
  - When the timer equals TIMEOUT-1 and led_valid=0: go to HUNT, pulse err, increment err_count (saturating), clear the timer.
- dir is registered alongside phase: dir = (next phase ≥ 3).
- cycle_count and err_count are never cleared except by rst.

## Timing
- All outputs are registered. The response to a led_valid sampled at edge N is visible after edge N, one cycle of latency.
- err is high for exactly one cycle per event and is never held.
- Reset values: locked=0, phase=0, dir=0, err=0, err_count=0, cycle_count=0, idle timer=0, state HUNT.
- rst has priority over led_valid and over timeout in the same cycle.
- Reset mid-sequence returns to HUNT immediately. The first post-reset anchor relocks.
- led_valid has priority over timeout in the same cycle: the pattern is checked and the timer cleared, with no timeout error.
- err_count at 255: a further error still pulses err, and the count stays 255.
- cycle_count at 16'hFFFF plus one completion wraps to 0.
- Back-to-back led_valid (every cycle) is legal; each pattern is checked independently.

## Test plan
- Reset, then valid strobes 81,42,24,18,24,42,81:
  - locked=1 after the first strobe.
  - phase 0,1,2,3,4,5,0; dir 0,0,0,1,1,1,0.
  - cycle_count=1, err never high.
- Reset, then 42, 24 (HUNT, locked=0, no err), then 18:
  - locked=1, phase=3, dir=1. Next 24 gives phase=4.
- Locked at phase 1 (after 81,42), feed 18:
  - err pulses one cycle, err_count=1, locked stays 1, phase=3.
  - Then feed 42 (expected 24): err, err_count=2, locked=0.
- TIMEOUT=16, lock on 81, then no strobes:
  - locked drops and err pulses exactly 16 cycles after the strobe edge, err_count=1.
  - A strobe on cycle 15 instead keeps the lock with no err.
- Locked, then 300 consecutive non-anchor mismatching strobes (alternating relock via 81):
  - err_count saturates at 255 and err still pulses.
- Mid-sequence rst asserted together with led_valid=1, led_in=81:
  - All outputs return to reset values and locked stays 0.
  - The following 18 relocks at phase 3.
